// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle MIPS sequencer. Each instruction is split into FETCH, DECODE,
// EXECUTE, MEMORY and WRITEBACK steps. The block drives the shared ALU, the
// instruction register, the register file and one unified memory port that
// uses a req/ready handshake.
//
// Build option:
//   ILLEGAL_TRAP_EN  defined   : an unknown opcode traps. The FSM stays in
//                                ILLEGAL, illegal_op is sticky and no more
//                                fetches happen until reset.
//                    undefined : an unknown opcode is a one-cycle NOP and
//                                illegal_op is tied to 0.
//
// Parameters:
//   MEM_WAIT_MAX  number of cycles mem_req may wait before mem_timeout (1..255)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   opcode[5:0]                IR[31:26], valid from DECODE onward
//   zero                       ALU zero flag (branch decision)
//   mem_ready                  memory completes the current access
//   mem_req, mem_we, iord      memory request, write qualifier, address select
//   ir_write, pc_write, pc_src IR load, PC load, PC source select
//   reg_dst, mem_to_reg,
//   reg_write                  register file controls
//   alu_src_a, alu_src_b,
//   alu_op                     ALU operand selects and operation
//   instr_done                 one-cycle pulse in each instruction's last state
//   mem_timeout                sticky memory wait timeout flag
//   illegal_op                 sticky illegal opcode flag (trap build only)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       instr_done,
    output logic       mem_timeout,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_MEM_ADDR,
        S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic       illegal_op_q, illegal_op_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            illegal_op_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE:                    state_d = S_R_EXEC;
                    OP_LW, OP_SW:                state_d = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_XORI, OP_LUI, OP_SLTI:    state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:              state_d = S_BRANCH;
                    OP_J:                        state_d = S_JUMP;
                    default:                     state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL:   state_d = S_ILLEGAL;
`else
            S_ILLEGAL:   state_d = S_FETCH;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

    // Output decode: Moore on state, except the memory-completion and branch
    // qualifiers which look at mem_ready / zero in the same cycle.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 4'b0000;
        instr_done = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;          // PC + 4
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;          // speculative branch target
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 4'b1000;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                unique case (opcode)
                    OP_ANDI: alu_op = 4'b0001;
                    OP_ORI:  alu_op = 4'b0010;
                    OP_XORI: alu_op = 4'b0011;
                    OP_LUI:  alu_op = 4'b1010;
                    OP_SLTI: alu_op = 4'b1011;
                    default: alu_op = 4'b0000;
                endcase
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 4'b0110;
                pc_src     = 2'b01;
                pc_write   = (opcode == OP_BNE) ? ~zero : zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            S_ILLEGAL: begin
`ifndef ILLEGAL_TRAP_EN
                instr_done = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Memory wait counter: counts stalled request cycles, saturating at the
    // limit so the sticky flag cannot be missed through wrap-around.
    always_comb begin
        wait_cnt_d = '0;
        if (mem_req && !mem_ready) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
        mem_timeout_d = mem_timeout_q | (wait_cnt_d == WAIT_MAX);
`ifdef ILLEGAL_TRAP_EN
        illegal_op_d = illegal_op_q | (state_d == S_ILLEGAL);
`else
        illegal_op_d = 1'b0;
`endif
    end

    assign mem_timeout = mem_timeout_q;
    assign illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Every cycle of each instruction is
// compared as one packed control word against a hand-derived constant.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       instr_done, mem_timeout, illegal_op;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .mem_timeout(mem_timeout),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] ctl;
    assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done};

    function automatic logic [17:0] mk(input logic mreq, we, io, irw, pcw,
                                       input logic [1:0] pcs,
                                       input logic rd, m2r, rw, asa,
                                       input logic [1:0] asb,
                                       input logic [3:0] op,
                                       input logic done);
        return {mreq, we, io, irw, pcw, pcs, rd, m2r, rw, asa, asb, op, done};
    endfunction

    // Hand-derived control words
    logic [17:0] W_FETCH_WAIT, W_FETCH_RDY, W_DECODE, W_R_EXEC, W_R_WB, W_I_WB;
    logic [17:0] W_MEM_ADDR, W_MEM_READ, W_MEM_WB, W_MEM_WR_WAIT, W_MEM_WR_RDY;
    logic [17:0] W_BR_TAKEN, W_BR_NOT, W_JUMP, W_ILL_NOP, W_ILL_TRAP;

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs for the current cycle, compare, then advance one clock.
    task automatic cyc(input string tag, input logic rdy, input logic [5:0] op,
                       input logic z, input logic [17:0] exp);
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
        #1;
        chk(tag, ctl, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        W_FETCH_WAIT  = mk(1,0,0,0,0,2'b00,0,0,0,0,2'b01,4'b0000,0);
        W_FETCH_RDY   = mk(1,0,0,1,1,2'b00,0,0,0,0,2'b01,4'b0000,0);
        W_DECODE      = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b11,4'b0000,0);
        W_R_EXEC      = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b00,4'b1000,0);
        W_R_WB        = mk(0,0,0,0,0,2'b00,1,0,1,0,2'b00,4'b0000,1);
        W_I_WB        = mk(0,0,0,0,0,2'b00,0,0,1,0,2'b00,4'b0000,1);
        W_MEM_ADDR    = mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,4'b0000,0);
        W_MEM_READ    = mk(1,0,1,0,0,2'b00,0,0,0,0,2'b00,4'b0000,0);
        W_MEM_WB      = mk(0,0,0,0,0,2'b00,0,1,1,0,2'b00,4'b0000,1);
        W_MEM_WR_WAIT = mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,4'b0000,0);
        W_MEM_WR_RDY  = mk(1,1,1,0,0,2'b00,0,0,0,0,2'b00,4'b0000,1);
        W_BR_TAKEN    = mk(0,0,0,0,1,2'b01,0,0,0,1,2'b00,4'b0110,1);
        W_BR_NOT      = mk(0,0,0,0,0,2'b01,0,0,0,1,2'b00,4'b0110,1);
        W_JUMP        = mk(0,0,0,0,1,2'b10,0,0,0,0,2'b00,4'b0000,1);
        W_ILL_NOP     = mk(0,0,0,0,0,2'b00,0,0,0,0,2'b00,4'b0000,1);
        W_ILL_TRAP    = '0;

        // Reset
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        #1;
        chk("reset_ctl", ctl, W_FETCH_WAIT);
        chk("reset_timeout", {17'b0, mem_timeout}, 18'd0);
        chk("reset_illegal", {17'b0, illegal_op}, 18'd0);
        rst_n = 1'b1;

        // R-type, 4 cycles
        cyc("r_fetch",  1, 6'b000000, 0, W_FETCH_RDY);
        cyc("r_decode", 1, 6'b000000, 0, W_DECODE);
        cyc("r_exec",   1, 6'b000000, 0, W_R_EXEC);
        cyc("r_wb",     1, 6'b000000, 0, W_R_WB);

        // ori and lui: alu_op from opcode
        cyc("ori_fetch",  1, 6'b001101, 0, W_FETCH_RDY);
        cyc("ori_decode", 1, 6'b001101, 0, W_DECODE);
        cyc("ori_exec",   1, 6'b001101, 0, mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,4'b0010,0));
        cyc("ori_wb",     1, 6'b001101, 0, W_I_WB);
        cyc("lui_fetch",  1, 6'b001111, 0, W_FETCH_RDY);
        cyc("lui_decode", 1, 6'b001111, 0, W_DECODE);
        cyc("lui_exec",   1, 6'b001111, 0, mk(0,0,0,0,0,2'b00,0,0,0,1,2'b10,4'b1010,0));
        cyc("lui_wb",     1, 6'b001111, 0, W_I_WB);

        // lw with 3 wait cycles in MEM_READ: 8 cycles total.
        // mem_ready low in DECODE/MEM_ADDR must be ignored.
        cyc("lw_fetch",  1, 6'b100011, 0, W_FETCH_RDY);
        cyc("lw_decode", 0, 6'b100011, 0, W_DECODE);
        cyc("lw_addr",   0, 6'b100011, 0, W_MEM_ADDR);
        for (int i = 0; i < 3; i++) cyc("lw_read_wait", 0, 6'b100011, 0, W_MEM_READ);
        cyc("lw_read_rdy", 1, 6'b100011, 0, W_MEM_READ);
        cyc("lw_wb",       1, 6'b100011, 0, W_MEM_WB);

        // sw, 4 cycles
        cyc("sw_fetch",  1, 6'b101011, 0, W_FETCH_RDY);
        cyc("sw_decode", 1, 6'b101011, 0, W_DECODE);
        cyc("sw_addr",   1, 6'b101011, 0, W_MEM_ADDR);
        cyc("sw_write",  1, 6'b101011, 0, W_MEM_WR_RDY);

        // beq zero=1 taken, beq zero=0 not taken, bne zero=1 not taken
        cyc("beq_fetch",  1, 6'b000100, 1, W_FETCH_RDY);
        cyc("beq_decode", 1, 6'b000100, 1, W_DECODE);
        cyc("beq_z1",     1, 6'b000100, 1, W_BR_TAKEN);
        cyc("beq0_fetch", 1, 6'b000100, 0, W_FETCH_RDY);
        cyc("beq0_decode",1, 6'b000100, 0, W_DECODE);
        cyc("beq_z0",     1, 6'b000100, 0, W_BR_NOT);
        cyc("bne_fetch",  1, 6'b000101, 1, W_FETCH_RDY);
        cyc("bne_decode", 1, 6'b000101, 1, W_DECODE);
        cyc("bne_z1",     1, 6'b000101, 1, W_BR_NOT);

        // j, 3 cycles
        cyc("j_fetch",  1, 6'b000010, 0, W_FETCH_RDY);
        cyc("j_decode", 1, 6'b000010, 0, W_DECODE);
        cyc("j_jump",   1, 6'b000010, 0, W_JUMP);

        // Fetch stall: timeout after exactly 15 waiting cycles, FSM stays put
        for (int i = 1; i <= 15; i++) begin
            cyc("to_fetch_wait", 0, 6'b111111, 0, W_FETCH_WAIT);
            chk("to_flag", {17'b0, mem_timeout}, (i == 15) ? 18'd1 : 18'd0);
        end
        cyc("to_fetch_wait16", 0, 6'b111111, 0, W_FETCH_WAIT);
        cyc("to_fetch_rdy",    1, 6'b111111, 0, W_FETCH_RDY);
        chk("to_sticky", {17'b0, mem_timeout}, 18'd1);

        // Illegal opcode 111111
        cyc("ill_decode", 1, 6'b111111, 0, W_DECODE);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            cyc("ill_trap", 1, 6'b111111, 0, W_ILL_TRAP);
            chk("ill_flag", {17'b0, illegal_op}, 18'd1);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`else
        cyc("ill_nop", 1, 6'b111111, 0, W_ILL_NOP);
        chk("ill_flag_tied", {17'b0, illegal_op}, 18'd0);
`endif

        // Reset during MEM_WRITE wait
        cyc("rsw_fetch",  1, 6'b101011, 0, W_FETCH_RDY);
        cyc("rsw_decode", 1, 6'b101011, 0, W_DECODE);
        cyc("rsw_addr",   1, 6'b101011, 0, W_MEM_ADDR);
        cyc("rsw_wait1",  0, 6'b101011, 0, W_MEM_WR_WAIT);
        cyc("rsw_wait2",  0, 6'b101011, 0, W_MEM_WR_WAIT);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rsw_ctl", ctl, W_FETCH_WAIT);
        chk("rsw_timeout", {17'b0, mem_timeout}, 18'd0);
        chk("rsw_illegal", {17'b0, illegal_op}, 18'd0);
        rst_n = 1'b1;

        // Resume normal operation
        cyc("post_fetch",  1, 6'b000010, 0, W_FETCH_RDY);
        cyc("post_decode", 1, 6'b000010, 0, W_DECODE);
        cyc("post_jump",   1, 6'b000010, 0, W_JUMP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath. Replaces the single-cycle decoder with an FSM that breaks each instruction into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It drives the shared ALU, instruction register, register file and a single unified memory port through a req/ready handshake. It sits between the instruction register opcode/ALU zero flag and all datapath mux/enable controls.

Parameters:
MEM_WAIT_MAX, 15, max cycles mem_req may wait for mem_ready before mem_timeout asserts (1..255)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  synchronous active-low reset
opcode  input  6  instruction register bits [31:26], valid from DECODE onward
zero  input  1  ALU zero flag, combinational from current ALU operands
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request, held until mem_ready
mem_we  output  1  write qualifier for mem_req
iord  output  1  0: address=PC, 1: address=ALUOut
ir_write  output  1  load instruction register
pc_write  output  1  load PC
pc_src  output  2  00: ALU result, 01: ALUOut (branch target), 10: jump target
reg_dst  output  1  0: rt, 1: rd
mem_to_reg  output  1  0: ALUOut, 1: memory data register
reg_write  output  1  register file write enable
alu_src_a  output  1  0: PC, 1: rs
alu_src_b  output  2  00: rt, 01: const 4, 10: sign-ext imm, 11: sign-ext imm<<2
alu_op  output  4  0000 add, 0001 and, 0010 or, 0011 xor, 0110 sub, 1000 R-type funct, 1010 lui, 1011 slt
instr_done  output  1  one-cycle pulse in the final state of each instruction
mem_timeout  output  1  sticky flag, cleared only by reset
illegal_op  output  1  see Optional Feature; constant 0 when macro undefined

Behaviour:
- Reset (rst_n low at clk edge): state=FETCH, wait counter=0, mem_timeout=0, illegal_op=0. All outputs are Moore-decoded from state; in FETCH after reset only mem_req=1, alu_src_b=01, alu_op=0000. Every other output is 0.
- Unlisted outputs in each state are 0. No X values are driven in any state.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add. In the mem_ready cycle ir_write=1, pc_write=1, pc_src=00, then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011/101011 -> MEM_ADDR
  - 001000/001100/001101/001110/001111/001010 -> I_EXEC
  - 000100/000101 -> BRANCH
  - 000010 -> JUMP
  - others -> ILLEGAL
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=1000 -> R_WB.
- R_WB: reg_dst=1, reg_write=1, instr_done=1 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op by opcode (addi 0000, andi 0001, ori 0010, xori 0011, lui 1010, slti 1011) -> I_WB.
- I_WB: reg_dst=0, reg_write=1, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_req=1, iord=1. On mem_ready -> MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, iord=1. On mem_ready, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0110, pc_src=01. pc_write=zero for beq, ~zero for bne (Mealy on zero). instr_done=1 -> FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1 -> FETCH.
- Latency with mem_ready tied high: R/I-type 4, lw 5, sw 4, beq/bne 3, j 3 cycles.
- Wait counter: increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or when leaving a memory state. When counter reaches MEM_WAIT_MAX, mem_timeout sets. The FSM keeps waiting; the request is never dropped.
- mem_ready is ignored in non-memory states.
- rst_n low in any state, including mid-wait, wins over all transitions.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: ILLEGAL state is terminal. illegal_op=1 (sticky), all enables 0, no further fetches until reset.
- Undefined: ILLEGAL acts as NOP. One cycle with all enables 0, instr_done=1 -> FETCH. illegal_op tied 0.

Test Plan:
- Reset then mem_ready=1, opcode=000000 -> FETCH/DECODE/R_EXEC/R_WB in 4 cycles; reg_write=1 and reg_dst=1 in cycle 4; instr_done pulses once.
- lw (100011) with mem_ready low 3 cycles in MEM_READ -> mem_req and iord held 4 cycles; MEM_WB follows with mem_to_reg=1; total 8 cycles.
- beq (000100) with zero=1 -> pc_write=1 and pc_src=01 in BRANCH; bne with zero=1 -> pc_write=0.
- mem_ready held low in FETCH with MEM_WAIT_MAX=15 -> mem_timeout rises after 15 waiting cycles; FSM remains in FETCH; proceeds once mem_ready=1.
- opcode 111111 -> with ILLEGAL_TRAP_EN, illegal_op=1 and mem_req stays 0 forever; without it, instr_done pulse, then FETCH.
- rst_n=0 during MEM_WRITE wait -> next cycle FETCH, mem_we=0, mem_timeout=0.
